// File: rtl/mem_req_arbiter.sv
// ============================================================================
//  Module   : mem_req_arbiter
//  Brief    : Shares one SRAM-like bus between instruction fetch and data
//             access, with a per-side completion pulse and stall requests.
//             Optional watchdog enabled by macro ARB_TIMEOUT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_req_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic          clk,
    input  logic          rst,
    // instruction-fetch side
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    input  logic          i_cancel,
    output logic [DW-1:0] i_rdata,
    output logic          i_data_ok,
    // data-access side
    input  logic          d_req,
    input  logic          d_wr,
    input  logic [1:0]    d_size,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_data_ok,
    // shared bus
    output logic          bus_req,
    output logic          bus_wr,
    output logic [1:0]    bus_size,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    input  logic          bus_addr_ok,
    input  logic          bus_data_ok,
    input  logic [DW-1:0] bus_rdata,
    // hazard unit
    output logic          stall_if,
    output logic          stall_mem
`ifdef ARB_TIMEOUT_EN
    ,
    output logic          timeout_err
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam logic c_OWNER_I = 1'b0;
    localparam logic c_OWNER_D = 1'b1;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_owner;
    logic            r_discard;
    logic            r_wr;
    logic [1:0]      r_size;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;

    logic            w_grant_d;
    logic            w_grant_i;
    logic            w_busy;
    logic            w_done;

    // D wins ties in IDLE: the MEM-stage instruction is the older one.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_d   = 1'b0;
        w_grant_i   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (d_req) begin
                    w_grant_d   = 1'b1;
                    w_state_nxt = ST_ADDR;
                end else if (i_req && !i_cancel) begin
                    w_grant_i   = 1'b1;
                    w_state_nxt = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (bus_addr_ok) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bus_data_ok) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_owner   <= c_OWNER_I;
            r_discard <= 1'b0;
            r_wr      <= 1'b0;
            r_size    <= 2'd0;
            r_addr    <= '0;
            r_wdata   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant_d) begin
                r_owner <= c_OWNER_D;
                r_wr    <= d_wr;
                r_size  <= d_size;
                r_addr  <= d_addr;
                r_wdata <= d_wdata;
            end else if (w_grant_i) begin
                r_owner <= c_OWNER_I;
                r_wr    <= 1'b0;
                r_size  <= 2'd2;
                r_addr  <= i_addr;
                r_wdata <= '0;
            end
            // A cancelled fetch still drains on the bus; only its pulse is dropped.
            if (w_done) begin
                r_discard <= 1'b0;
            end else if (w_busy && (r_owner == c_OWNER_I) && i_cancel) begin
                r_discard <= 1'b1;
            end
        end
    end

    assign w_busy = (r_state != ST_IDLE);
    assign w_done = (r_state == ST_DATA) && bus_data_ok;

    always_comb begin
        bus_req   = (r_state == ST_ADDR);
        bus_wr    = w_busy ? r_wr    : 1'b0;
        bus_size  = w_busy ? r_size  : 2'd0;
        bus_addr  = w_busy ? r_addr  : '0;
        bus_wdata = w_busy ? r_wdata : '0;
    end

    assign i_data_ok = w_done && (r_owner == c_OWNER_I) && !r_discard;
    assign d_data_ok = w_done && (r_owner == c_OWNER_D);
    assign i_rdata   = bus_rdata;
    assign d_rdata   = bus_rdata;

    assign stall_mem = d_req && !d_data_ok;
    assign stall_if  = (i_req && !i_data_ok) ||
                       ((r_owner == c_OWNER_I) && r_discard && w_busy);

`ifdef ARB_TIMEOUT_EN
    localparam int c_CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(TIMEOUT_CYC);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYC - 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_timeout_err;
    logic               w_state_chg;

    assign w_state_chg = (w_state_nxt != r_state);

    // Error is flagged on the edge at which the count reaches the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt         <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_state_chg) begin
                r_cnt <= '0;
            end else if (w_busy && (r_cnt != c_CNT_MAX)) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_busy && !w_state_chg && (r_cnt == c_CNT_LAST)) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign timeout_err = r_timeout_err;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_req_arbiter.sv
// ============================================================================
//  Module   : tb_mem_req_arbiter
//  Brief    : Directed self-checking bench for mem_req_arbiter; the watchdog
//             scenario runs when ARB_TIMEOUT_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_req_arbiter;

`ifdef ARB_TIMEOUT_EN
    localparam int c_TCYC = 4;
`else
    localparam int c_TCYC = 255;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_cancel, i_data_ok;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_wr, d_data_ok;
    logic [1:0]  d_size;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        bus_req, bus_wr, bus_addr_ok, bus_data_ok;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic        stall_if, stall_mem;
`ifdef ARB_TIMEOUT_EN
    logic        timeout_err;
`endif

    int vecs = 0;
    int errs = 0;

    mem_req_arbiter #(.AW(32), .DW(32), .TIMEOUT_CYC(c_TCYC)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_cancel(i_cancel),
        .i_rdata(i_rdata), .i_data_ok(i_data_ok),
        .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_data_ok(d_data_ok),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem)
`ifdef ARB_TIMEOUT_EN
        , .timeout_err(timeout_err)
`endif
    );

    always #5 clk = ~clk;

    // Inputs change 1 ns after the rising edge; checks follow 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_req = 0; i_addr = '0; i_cancel = 0;
        d_req = 0; d_wr = 0; d_size = 0; d_addr = '0; d_wdata = '0;
        bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        step(); step();
        rst = 0;
        #1;
        vecs++; if (bus_req !== 1'b0) begin errs++; $display("FAIL rst_bus_req: got %0h want 0", bus_req); end
        vecs++; if (bus_addr !== 32'h0) begin errs++; $display("FAIL rst_bus_addr: got %0h want 0", bus_addr); end
        vecs++; if ({bus_wr, bus_size, bus_wdata} !== 35'h0) begin errs++; $display("FAIL rst_bus_fields: got %0h want 0", {bus_wr, bus_size, bus_wdata}); end
        vecs++; if ({i_data_ok, d_data_ok, stall_if, stall_mem} !== 4'b0) begin errs++; $display("FAIL rst_flags: got %b want 0000", {i_data_ok, d_data_ok, stall_if, stall_mem}); end
    endtask

    task automatic test_lone_fetch();
        step();
        i_req = 1; i_addr = 32'hBFC00000;                     // cycle N
        #1;
        vecs++; if (stall_if !== 1'b1) begin errs++; $display("FAIL lone_stall_N: got %0h want 1", stall_if); end
        vecs++; if (bus_req !== 1'b0) begin errs++; $display("FAIL lone_bus_req_N: got %0h want 0", bus_req); end
        step();                                               // N+1
        vecs++; if (bus_req !== 1'b1) begin errs++; $display("FAIL lone_bus_req_N1: got %0h want 1", bus_req); end
        vecs++; if (bus_addr !== 32'hBFC00000) begin errs++; $display("FAIL lone_bus_addr: got %0h want bfc00000", bus_addr); end
        vecs++; if ({bus_wr, bus_size} !== 3'b010) begin errs++; $display("FAIL lone_wr_size: got %b want 010", {bus_wr, bus_size}); end
        vecs++; if (stall_if !== 1'b1) begin errs++; $display("FAIL lone_stall_N1: got %0h want 1", stall_if); end
        bus_addr_ok = 1;
        step();                                               // N+2
        bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h3C080001;
        #1;
        vecs++; if (bus_req !== 1'b0) begin errs++; $display("FAIL lone_bus_req_N2: got %0h want 0", bus_req); end
        vecs++; if (i_data_ok !== 1'b1) begin errs++; $display("FAIL lone_data_ok: got %0h want 1", i_data_ok); end
        vecs++; if (i_rdata !== 32'h3C080001) begin errs++; $display("FAIL lone_rdata: got %0h want 3c080001", i_rdata); end
        vecs++; if (d_data_ok !== 1'b0) begin errs++; $display("FAIL lone_d_ok: got %0h want 0", d_data_ok); end
        vecs++; if (stall_if !== 1'b0) begin errs++; $display("FAIL lone_stall_N2: got %0h want 0", stall_if); end
        step();                                               // N+3: data_ok held, must be ignored
        i_req = 0;
        #1;
        vecs++; if (i_data_ok !== 1'b0) begin errs++; $display("FAIL lone_second_pulse: got %0h want 0", i_data_ok); end
        vecs++; if (bus_addr !== 32'h0) begin errs++; $display("FAIL lone_idle_addr: got %0h want 0", bus_addr); end
        bus_data_ok = 0;
    endtask

    task automatic test_contention();
        step();
        i_req = 1; i_addr = 32'hBFC00004;
        d_req = 1; d_wr = 1; d_size = 2; d_addr = 32'h80001000; d_wdata = 32'hDEADBEEF;
        step();
        vecs++; if (bus_req !== 1'b1 || bus_wr !== 1'b1) begin errs++; $display("FAIL cont_store_req_wr: got %b want 11", {bus_req, bus_wr}); end
        vecs++; if (bus_addr !== 32'h80001000) begin errs++; $display("FAIL cont_store_addr: got %0h want 80001000", bus_addr); end
        vecs++; if (bus_wdata !== 32'hDEADBEEF) begin errs++; $display("FAIL cont_store_wdata: got %0h want deadbeef", bus_wdata); end
        vecs++; if ({stall_if, stall_mem} !== 2'b11) begin errs++; $display("FAIL cont_stalls_addr: got %b want 11", {stall_if, stall_mem}); end
        bus_addr_ok = 1;
        step();
        bus_addr_ok = 0; bus_data_ok = 1;
        #1;
        vecs++; if ({d_data_ok, i_data_ok} !== 2'b10) begin errs++; $display("FAIL cont_store_done: got %b want 10", {d_data_ok, i_data_ok}); end
        vecs++; if ({stall_if, stall_mem} !== 2'b10) begin errs++; $display("FAIL cont_stalls_done: got %b want 10", {stall_if, stall_mem}); end
        step();
        d_req = 0; d_wr = 0; bus_data_ok = 0;
        #1;
        vecs++; if (bus_req !== 1'b0 || stall_if !== 1'b1) begin errs++; $display("FAIL cont_gap: got req=%0h stall_if=%0h want 0 1", bus_req, stall_if); end
        step();
        vecs++; if (bus_req !== 1'b1 || bus_addr !== 32'hBFC00004 || bus_wr !== 1'b0) begin errs++; $display("FAIL cont_fetch_grant: got req=%0h addr=%0h wr=%0h want 1 bfc00004 0", bus_req, bus_addr, bus_wr); end
        bus_addr_ok = 1;
        step();
        bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h24020005;
        #1;
        vecs++; if (i_data_ok !== 1'b1 || i_rdata !== 32'h24020005) begin errs++; $display("FAIL cont_fetch_done: got ok=%0h data=%0h want 1 24020005", i_data_ok, i_rdata); end
        step();
        i_req = 0; bus_data_ok = 0;
    endtask

    task automatic test_slow_slave();
        step();
        d_req = 1; d_wr = 0; d_size = 0; d_addr = 32'h80000010;
        step();
        bus_data_ok = 1;                                      // must be ignored in ADDR
        for (int k = 0; k < 3; k++) begin
            #1;
            vecs++; if (bus_req !== 1'b1 || bus_addr !== 32'h80000010 || bus_size !== 2'd0) begin errs++; $display("FAIL slow_hold_%0d: got req=%0h addr=%0h size=%0h want 1 80000010 0", k, bus_req, bus_addr, bus_size); end
            vecs++; if (d_data_ok !== 1'b0 || stall_mem !== 1'b1) begin errs++; $display("FAIL slow_nopulse_%0d: got ok=%0h stall=%0h want 0 1", k, d_data_ok, stall_mem); end
            step();
        end
        bus_data_ok = 0; bus_addr_ok = 1;
        step();
        bus_addr_ok = 0;
        #1;
        vecs++; if (d_data_ok !== 1'b0 || bus_req !== 1'b0) begin errs++; $display("FAIL slow_data_wait: got ok=%0h req=%0h want 0 0", d_data_ok, bus_req); end
        step();
        bus_data_ok = 1; bus_rdata = 32'h000000A5;
        #1;
        vecs++; if (d_data_ok !== 1'b1 || d_rdata !== 32'h000000A5 || stall_mem !== 1'b0) begin errs++; $display("FAIL slow_done: got ok=%0h data=%0h stall=%0h want 1 a5 0", d_data_ok, d_rdata, stall_mem); end
        step();
        d_req = 0; bus_data_ok = 0;
    endtask

    task automatic test_cancel();
        step();
        i_req = 1; i_addr = 32'hBFC00100;
        step();
        bus_addr_ok = 1;
        step();
        bus_addr_ok = 0; i_cancel = 1;                        // DATA, flush
        #1;
        vecs++; if (stall_if !== 1'b1) begin errs++; $display("FAIL cancel_stall_flush: got %0h want 1", stall_if); end
        step();
        i_cancel = 0; i_addr = 32'hBFC00380; bus_data_ok = 1; bus_rdata = 32'h11111111;
        #1;
        vecs++; if (i_data_ok !== 1'b0) begin errs++; $display("FAIL cancel_swallow: got %0h want 0", i_data_ok); end
        vecs++; if (stall_if !== 1'b1) begin errs++; $display("FAIL cancel_stall_drain: got %0h want 1", stall_if); end
        step();
        bus_data_ok = 0;
        #1;
        vecs++; if (bus_req !== 1'b0) begin errs++; $display("FAIL cancel_idle: got %0h want 0", bus_req); end
        step();
        vecs++; if (bus_req !== 1'b1 || bus_addr !== 32'hBFC00380) begin errs++; $display("FAIL cancel_refetch_addr: got req=%0h addr=%0h want 1 bfc00380", bus_req, bus_addr); end
        bus_addr_ok = 1;
        step();
        bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h12345678;
        #1;
        vecs++; if (i_data_ok !== 1'b1 || i_rdata !== 32'h12345678) begin errs++; $display("FAIL cancel_refetch_done: got ok=%0h data=%0h want 1 12345678", i_data_ok, i_rdata); end
        step();
        i_req = 0; bus_data_ok = 0;
    endtask

    task automatic test_reset_mid();
        step();
        i_req = 1; i_addr = 32'hBFC00200;
        step();
        bus_addr_ok = 1;
        step();
        bus_addr_ok = 0; rst = 1;                             // in DATA
        step();
        rst = 0; i_req = 0;
        #1;
        vecs++; if (bus_req !== 1'b0 || bus_addr !== 32'h0) begin errs++; $display("FAIL rstmid_idle: got req=%0h addr=%0h want 0 0", bus_req, bus_addr); end
        bus_data_ok = 1;
        #1;
        vecs++; if ({i_data_ok, d_data_ok, stall_if} !== 3'b000) begin errs++; $display("FAIL rstmid_late_data: got %b want 000", {i_data_ok, d_data_ok, stall_if}); end
        step();
        bus_data_ok = 0;
        #1;
        vecs++; if (bus_req !== 1'b0) begin errs++; $display("FAIL rstmid_stay_idle: got %0h want 0", bus_req); end
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        step();
        d_req = 1; d_wr = 0; d_size = 2; d_addr = 32'h80002000;
        for (int k = 1; k <= 6; k++) begin
            step();                                           // ADDR cycle k
            vecs++; if (timeout_err !== (k >= 5)) begin errs++; $display("FAIL timeout_cyc%0d: got %0h want %0h", k, timeout_err, (k >= 5)); end
        end
        bus_addr_ok = 1;
        step();
        bus_addr_ok = 0; bus_data_ok = 1;
        step();
        d_req = 0; bus_data_ok = 0;
        step();
        vecs++; if (timeout_err !== 1'b1) begin errs++; $display("FAIL timeout_sticky: got %0h want 1", timeout_err); end
        rst = 1;
        step();
        rst = 0;
        #1;
        vecs++; if (timeout_err !== 1'b0) begin errs++; $display("FAIL timeout_rst: got %0h want 0", timeout_err); end
    endtask
`endif

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench watchdog");
    end

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_lone_fetch();
        test_contention();
        test_slow_slave();
        test_cancel();
        test_reset_mid();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Shares the CPU's single SRAM-like memory bus between the instruction-fetch side (IF) and the data-access side (MEM, lw/sw).
- Grants one transaction at a time and holds the bus handshake for the whole transaction.
- Returns data only to the side that owns the transaction.
- Raises per-stage stall requests that the hazard unit ORs into stallF/stallD and the MEM-stage stall.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- TIMEOUT_CYC, 255, watchdog limit in cycles. Used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- i_req  in  1  fetch request; held high until i_data_ok.
- i_addr  in  AW  fetch address; stable while i_req is high.
- i_cancel  in  1  pipeline flush (exception or redirect); kills the pending fetch.
- i_rdata  out  DW  fetch data; valid only when i_data_ok is high.
- i_data_ok  out  1  fetch-complete pulse.
- d_req  in  1  data request; held high until d_data_ok.
- d_wr  in  1  1 = store, 0 = load.
- d_size  in  2  access size: 0 = byte, 1 = half, 2 = word.
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_rdata  out  DW  load data; valid only when d_data_ok is high.
- d_data_ok  out  1  data-complete pulse.
- bus_req  out  1  bus request.
- bus_wr  out  1  bus write enable.
- bus_size  out  2  bus access size.
- bus_addr  out  AW  bus address.
- bus_wdata  out  DW  bus write data.
- bus_addr_ok  in  1  address accepted by the bus.
- bus_data_ok  in  1  data phase complete.
- bus_rdata  in  DW  bus read data.
- stall_if  out  1  fetch-stage stall request.
- stall_mem  out  1  MEM-stage stall request.
- timeout_err  out  1  sticky watchdog error. Present only with ARB_TIMEOUT_EN.

Behaviour:
- States:
  - IDLE: no transaction.
  - ADDR: bus_req high, waiting for bus_addr_ok.
  - DATA: waiting for bus_data_ok.
- Registers: owner (0 = I, 1 = D), discard flag, latched request fields (wr, size, addr, wdata).
- IDLE transitions:
  - d_req high: grant D, latch the D fields, go to ADDR. D wins over I when both request in the same cycle, because the MEM instruction is older.
  - Otherwise, i_req high and i_cancel low: grant I, latch wr=0, size=2, addr=i_addr, go to ADDR.
  - i_req high with i_cancel high: no grant.
- ADDR:
  - bus_req=1 and bus_* driven from the latched fields.
  - bus_addr_ok high: go to DATA. bus_req is low from the next cycle.
  - The request fields never change while in ADDR.
- DATA:
  - bus_data_ok high: go to IDLE.
  - bus_data_ok is ignored in IDLE and ADDR.
- Completion pulses:
  - i_data_ok = DATA & bus_data_ok & owner==I & ~discard.
  - d_data_ok = DATA & bus_data_ok & owner==D.
  - Both are combinational, single-cycle pulses.
  - i_rdata and d_rdata both pass bus_rdata through.
- Minimum latency:
  - Request seen at cycle N, bus_req at N+1, addr_ok at N+1, data_ok at N+2, data_ok pulse at N+2.
  - The earliest next grant is at the edge ending N+3.
- Cancel:
  - i_cancel high while owner==I in ADDR or DATA sets discard. The transaction still runs to completion on the bus, since the handshake cannot be withdrawn.
  - The completion is swallowed: no i_data_ok.
  - discard clears on the return to IDLE.
  - Cancel of a D transaction is not supported; the MEM stage is never flushed mid-access.
- Stall requests:
  - stall_mem = d_req & ~d_data_ok.
  - stall_if = (i_req & ~i_data_ok) | (owner==I & discard & state!=IDLE). While a discarded fetch drains, the new-PC fetch waits.
- Outputs are zero when idle: bus_req=0, bus_wr=0, bus_size=0, bus_addr=0, bus_wdata=0.
- Reset:
  - state=IDLE, owner=0, discard=0, latches=0, all outputs 0.
  - Reset mid-transaction aborts with no pulse. The bus slave is reset by the same rst.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- When defined:
  - An 8-bit counter (width covers TIMEOUT_CYC) clears on every state change and increments each cycle in ADDR or DATA.
  - Reaching TIMEOUT_CYC sets timeout_err, which stays high until rst.
  - The arbiter keeps waiting; no forced completion.
- When undefined: no counter, no timeout_err port.

Test Plan:
- Lone fetch: i_req=1, i_addr=0xBFC00000, addr_ok at N+1, data_ok at N+2 with rdata 0x3C080001 -> bus_addr=0xBFC00000, bus_wr=0; i_data_ok pulses once at N+2 with i_rdata=0x3C080001; stall_if high through N+1.
- Contention: i_req and d_req (store, 0x80001000, wdata 0xDEADBEEF, size 2) rise in the same cycle -> store granted first with bus_wr=1, bus_wdata=0xDEADBEEF; fetch is granted only after d_data_ok; stall_if stays high throughout.
- Slow slave: addr_ok delayed 3 cycles -> bus_req and bus_addr stay stable for all 3 cycles; no data pulse before data_ok.
- Cancel: i_cancel pulses while the I transaction is in DATA -> no i_data_ok; stall_if stays high until IDLE; the next fetch at 0xBFC00380 completes normally.
- Reset mid-DATA: rst for 1 cycle -> bus_req=0 and state IDLE next cycle; a later data_ok produces no pulse.
- With ARB_TIMEOUT_EN and TIMEOUT_CYC=4: bus_addr_ok held low for 6 cycles -> timeout_err rises after 4 cycles in ADDR and stays 1 until rst.
